mc_traffic_gen: RTL and testbench
=================================

# mc_traffic_gen

Synthesizable stimulus/checker stage that sits directly upstream of `memory_controller` and drives its host request port. It runs a write-all/read-all sweep: NUM_REQ sequential writes with data = address, then NUM_REQ reads of the same addresses. It checks every returned read word, then reports pass/fail and cycle statistics. It replaces the behavioural bench loop so the sweep runs at full speed on the emulator.

## Interface
- DATA_WIDTH, 16, width of `in_request_data` / `data_out`
- ADDR_WIDTH, 30, width of `in_request_address`
- NUM_REQ, 1024, requests per phase; legal range 1 to 2^ADDR_WIDTH
- IDLE_TIMEOUT, 200, drain cycles allowed with no completion
- CYC_W, 32, width of cycle counters
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE
- out_busy  in  1  controller back-pressure
- write_done  in  1  one write completed
- read_done  in  1  one read completed; `data_out` valid this cycle
- data_out  in  DATA_WIDTH  read data
- in_valid  out  1  request valid
- in_request_type  out  1  1 = write, 0 = read
- in_request_address  out  ADDR_WIDTH  request address
- in_request_data  out  DATA_WIDTH  write data; don't-care on reads
- done  out  1  sweep finished; held until next start
- pass  out  1  qualified by done
- timeout  out  1  drain ended by IDLE_TIMEOUT
- error_count  out  16  read mismatches plus unexpected completions; saturates at 16'hFFFF
- issue_cycles  out  CYC_W  cycles from start to acceptance of the last read
- total_cycles  out  CYC_W  cycles from start to entry into DONE

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE → WRITE on start. DONE → WRITE on start.
  - Entering WRITE clears all counters and status outputs (done, pass, timeout, error_count, cycle counters).
- Request handshake:
  - A request is accepted at a rising edge where in_valid=1 and out_busy=0.
  - in_valid is 1 exactly in WRITE and READ.
  - While out_busy=1, address, type and data are held stable.
- Issue index idx runs 0..NUM_REQ-1.
  - Address = idx, zero-extended to ADDR_WIDTH.
  - Data = idx[DATA_WIDTH-1:0].
  - Type = 1 in WRITE, 0 in READ.
- WRITE → READ on acceptance of idx = NUM_REQ-1; idx resets to 0.
- READ → DRAIN on acceptance of idx = NUM_REQ-1.
- Completion tracking runs in WRITE, READ and DRAIN, because completions can overlap issue.
  - wr_cnt increments on write_done; rd_cnt increments on read_done.
  - Both increment in the same cycle if both strobes are set.
- Read check: on read_done, compare data_out with rd_cnt[DATA_WIDTH-1:0]. Completions return in order.
  - A mismatch increments error_count.
- Any strobe arriving after its counter has reached NUM_REQ increments error_count, and the counter does not advance.
- Any strobe in IDLE or DONE is ignored.
- DRAIN → DONE when wr_cnt = NUM_REQ and rd_cnt = NUM_REQ. This check also applies on the cycle the last strobe arrives.
- DRAIN → DONE with timeout=1 when the idle counter reaches IDLE_TIMEOUT.
  - The idle counter clears on DRAIN entry and on any strobe.
- In DONE: pass = (error_count = 0) and timeout = 0.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: in_valid, in_request_type, in_request_address, in_request_data, done, pass, timeout, error_count, both cycle counters.
  - All internal counters 0.
- The first in_valid appears the cycle after start is sampled.
- in_valid and request fields are driven from state/idx registers only. There is no combinational path from out_busy to any output.
- Back-to-back acceptance is supported: one request per cycle when out_busy=0.
- done, pass and timeout go high in the first DONE cycle.
- total_cycles counts every cycle spent in WRITE, READ and DRAIN.
- issue_cycles freezes on the cycle the last read is accepted.
- Asserting rst_n low mid-sweep returns to IDLE immediately with all outputs at reset values. No partial request is retried.
- start is ignored in WRITE, READ and DRAIN.

## Structure
- Package `mc_tg_pkg`:
  - state enum `tg_state_t`.
  - constants `REQ_WRITE = 1'b1`, `REQ_READ = 1'b0`.
- Sub-module `mc_tg_checker`:
  - owns wr_cnt, rd_cnt, compare logic, error_count saturation and the idle counter.
  - outputs all_done and idle_expired to the top FSM.
- Top holds the FSM, issue index and cycle counters.

## Test plan
- Ideal controller stub (out_busy=0, fixed 5-cycle completion, echoing data), NUM_REQ=1024:
  - 2048 accepts, addresses 0..1023 twice.
  - done=1, pass=1, error_count=0.
  - issue_cycles=2048.
- Stub asserts out_busy every other cycle:
  - request fields stay stable while busy.
  - issue_cycles=4096.
  - pass=1.
- Stub corrupts the read of address 7 (returns 16'h0000 instead of 16'h0007):
  - error_count=1, pass=0, timeout=0.
- Stub drops the last read completion:
  - DONE entered exactly IDLE_TIMEOUT=200 cycles after the previous strobe.
  - timeout=1, pass=0.
- write_done and read_done in the same cycle, plus one extra write_done after wr_cnt=NUM_REQ:
  - both counters advance correctly.
  - error_count=1.
- rst_n pulsed low during READ at idx=300:
  - all outputs return to 0 asynchronously.
  - a following start re-runs the full sweep to pass=1.

Source files
------------

// File: rtl/mc_tg_pkg.sv
// Shared types and constants for the memory-controller traffic generator.
package mc_tg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } tg_state_t;

    localparam logic REQ_WRITE = 1'b1;
    localparam logic REQ_READ  = 1'b0;

endpackage

// File: rtl/mc_tg_checker.sv
// Completion tracker: counts write/read completions, checks read data in order,
// keeps a saturating error count and the drain idle counter.
module mc_tg_checker #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CNT_W        = 31,
    parameter int unsigned NUM_REQ      = 1024,
    parameter int unsigned IDLE_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  track,
    input  logic                  drain,
    input  logic                  write_done,
    input  logic                  read_done,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  all_done,
    output logic                  idle_expired,
    output logic [15:0]           error_count
);
    import mc_tg_pkg::*;

    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] NUM_REQ_C = CNT_W'(NUM_REQ);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [15:0]      err_q, err_d;
    logic [16:0]      err_sum;
    logic [1:0]       err_inc;
    logic [IW-1:0]    idle_q, idle_d;

    // Next-state for counters; a strobe past a full counter is an error and never advances it.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        idle_d   = idle_q;
        err_inc  = 2'd0;
        err_sum  = {1'b0, err_q};
        err_d    = err_q;
        if (clear) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            idle_d   = '0;
            err_d    = '0;
        end else if (track) begin
            if (write_done) begin
                if (wr_cnt_q == NUM_REQ_C) begin
                    err_inc = err_inc + 2'd1;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
            if (read_done) begin
                if (rd_cnt_q == NUM_REQ_C) begin
                    err_inc = err_inc + 2'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (data_out != DATA_WIDTH'(rd_cnt_q)) begin
                        err_inc = err_inc + 2'd1;
                    end
                end
            end
            err_sum = {1'b0, err_q} + 17'(err_inc);
            err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
            // Idle time only accrues in drain; entry and any completion restart it.
            idle_d  = (!drain || write_done || read_done) ? '0 : idle_q + IW'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            idle_q   <= '0;
            err_q    <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
        end
    end

    // Look-ahead so the final strobe itself can end the drain.
    assign all_done     = (wr_cnt_d == NUM_REQ_C) && (rd_cnt_d == NUM_REQ_C);
    assign idle_expired = drain && (idle_d == IW'(IDLE_TIMEOUT));
    assign error_count  = err_q;

endmodule

// File: rtl/mc_traffic_gen.sv
// Write-all / read-all sweep generator and checker for memory_controller.
module mc_traffic_gen #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned NUM_REQ      = 1024,
    parameter int unsigned IDLE_TIMEOUT = 200,
    parameter int unsigned CYC_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  out_busy,
    input  logic                  write_done,
    input  logic                  read_done,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  in_valid,
    output logic                  in_request_type,
    output logic [ADDR_WIDTH-1:0] in_request_address,
    output logic [DATA_WIDTH-1:0] in_request_data,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           error_count,
    output logic [CYC_W-1:0]      issue_cycles,
    output logic [CYC_W-1:0]      total_cycles
);
    import mc_tg_pkg::*;

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REQ - 1);

    tg_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CYC_W-1:0]      issue_q, issue_d;
    logic [CYC_W-1:0]      total_q, total_d;
    logic                  timeout_q, timeout_d;
    logic                  issuing, accept, clear, track, all_done, idle_expired;

    assign issuing = (state_q == StWrite) || (state_q == StRead);
    assign accept  = issuing && !out_busy;
    assign clear   = start && ((state_q == StIdle) || (state_q == StDone));
    assign track   = issuing || (state_q == StDrain);

    // FSM next-state, issue index and cycle statistics.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        issue_d   = issue_q;
        total_d   = total_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StWrite;
                    idx_d     = '0;
                    issue_d   = '0;
                    total_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            StWrite, StRead: begin
                issue_d = issue_q + CYC_W'(1);
                total_d = total_q + CYC_W'(1);
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == StWrite) ? StRead : StDrain;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                total_d = total_q + CYC_W'(1);
                if (all_done) begin
                    state_d = StDone;
                end else if (idle_expired) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            issue_q   <= '0;
            total_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            issue_q   <= issue_d;
            total_q   <= total_d;
            timeout_q <= timeout_d;
        end
    end

    mc_tg_checker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CNT_W       (CNT_W),
        .NUM_REQ     (NUM_REQ),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .track       (track),
        .drain       (state_q == StDrain),
        .write_done  (write_done),
        .read_done   (read_done),
        .data_out    (data_out),
        .all_done    (all_done),
        .idle_expired(idle_expired),
        .error_count (error_count)
    );

    // Request fields come from registers only, so out_busy never reaches an output.
    assign in_valid           = issuing;
    assign in_request_type    = (state_q == StWrite) ? REQ_WRITE : REQ_READ;
    assign in_request_address = issuing ? idx_q : '0;
    assign in_request_data    = (state_q == StWrite) ? DATA_WIDTH'(idx_q) : '0;
    assign done               = (state_q == StDone);
    assign timeout            = timeout_q;
    assign pass               = done && !timeout_q && (error_count == 16'd0);
    assign issue_cycles       = issue_q;
    assign total_cycles       = total_q;

endmodule

// File: tb/tb_mc_traffic_gen.sv
// Bench for mc_traffic_gen: in-order controller stub with random busy/latency and a sweep model.
module tb_mc_traffic_gen;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 30;
    localparam int unsigned N  = 1024;
    localparam int unsigned TO = 200;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          out_busy = 1'b0;
    logic          write_done = 1'b0;
    logic          read_done = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          in_valid, in_request_type, done, pass, timeout;
    logic [AW-1:0] in_request_address;
    logic [DW-1:0] in_request_data;
    logic [15:0]   error_count;
    logic [CW-1:0] issue_cycles, total_cycles;

    logic [DW-1:0] mem [N];
    longint        wq_due[$];
    longint        rq_due[$];
    longint        rq_addr[$];
    int            errors = 0;
    int            checks = 0;
    longint        cyc = 0;

    mc_traffic_gen #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_REQ     (N),
        .IDLE_TIMEOUT(TO),
        .CYC_W       (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .out_busy          (out_busy),
        .write_done        (write_done),
        .read_done         (read_done),
        .data_out          (data_out),
        .in_valid          (in_valid),
        .in_request_type   (in_request_type),
        .in_request_address(in_request_address),
        .in_request_data   (in_request_data),
        .done              (done),
        .pass              (pass),
        .timeout           (timeout),
        .error_count       (error_count),
        .issue_cycles      (issue_cycles),
        .total_cycles      (total_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".in_valid"}, in_valid, 0);
        check({tag, ".type"}, in_request_type, 0);
        check({tag, ".addr"}, in_request_address, 0);
        check({tag, ".data"}, in_request_data, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".err"}, error_count, 0);
        check({tag, ".issue"}, issue_cycles, 0);
        check({tag, ".total"}, total_cycles, 0);
    endtask

    // One full sweep against the stub. Edge numbers are values of cyc; a request
    // seen valid and not busy at a negedge is accepted at edge cyc+1.
    task automatic run_sweep(input string name, input int busy_mode,
                             input int wl_lo, input int wl_hi, input int rl_lo, input int rl_hi,
                             input int corrupt_addr, input bit drop_last, input bit extra_wr,
                             input int reset_at, input bit rand_start);
        longint s, a, e, d, ra, last_strobe, done_edge, exp_done, last_wdue, last_rdue;
        int wr_acc, rd_acc, wr_cmp, rd_cmp, bad_req, stab_bad, exp_err;
        bit got_done, extra_sent, was_busy;
        logic h_type;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        a = 0; last_strobe = 0; done_edge = 0; last_wdue = 0; last_rdue = 0;
        wr_acc = 0; rd_acc = 0; wr_cmp = 0; rd_cmp = 0; bad_req = 0; stab_bad = 0; exp_err = 0;
        got_done = 0; extra_sent = 0; was_busy = 0;
        h_type = 0; h_addr = '0; h_data = '0;
        wq_due.delete(); rq_due.delete(); rq_addr.delete();

        @(posedge clk); #1;
        start = 1'b1; out_busy = 1'b0; write_done = 1'b0; read_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        for (int t = 0; t < 12000; t++) begin
            e = cyc + 1;
            case (busy_mode)
                1:       out_busy = ((e - s) % 2) == 1;
                2:       out_busy = $urandom_range(99, 0) < 30;
                default: out_busy = 1'b0;
            endcase
            start = rand_start && (rd_acc < int'(N)) && ($urandom_range(19, 0) == 0);
            data_out = DW'($urandom);
            write_done = 1'b0;
            read_done = 1'b0;
            if (wq_due.size() > 0 && wq_due[0] == e) begin
                void'(wq_due.pop_front());
                write_done = 1'b1;
                wr_cmp++;
                last_strobe = e;
            end
            if (rq_due.size() > 0 && rq_due[0] == e) begin
                void'(rq_due.pop_front());
                ra = rq_addr.pop_front();
                if (!(drop_last && rd_cmp == int'(N) - 1)) begin
                    read_done = 1'b1;
                    if (ra == longint'(corrupt_addr)) data_out = '0;
                    else if (ra < longint'(N)) data_out = mem[int'(ra)];
                    else data_out = 16'hdead;
                    if (data_out != DW'(rd_cmp)) exp_err++;
                    rd_cmp++;
                    last_strobe = e;
                end
            end
            if (extra_wr && !extra_sent && !write_done && wr_cmp == int'(N)
                && rd_acc == int'(N)) begin
                write_done = 1'b1;
                extra_sent = 1'b1;
                exp_err++;
                last_strobe = e;
            end

            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                done_edge = cyc;
                break;
            end
            if (reset_at >= 0 && wr_acc == int'(N) && rd_acc == reset_at && in_valid) begin
                rst_n = 1'b0;
                #1;
                check_zero_outputs({name, ".async_rst"});
                write_done = 1'b0; read_done = 1'b0; out_busy = 1'b0; start = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check_zero_outputs({name, ".held_rst"});
                rst_n = 1'b1;
                return;
            end
            if (in_valid != (rd_acc < int'(N))) bad_req++;
            if (was_busy && (!in_valid || in_request_type != h_type
                || in_request_address != h_addr || in_request_data != h_data)) stab_bad++;
            was_busy = in_valid && out_busy;
            h_type = in_request_type;
            h_addr = in_request_address;
            h_data = in_request_data;
            if (in_valid && !out_busy) begin
                if (wr_acc < int'(N)) begin
                    if (in_request_type != 1'b1 || in_request_address != AW'(wr_acc)
                        || in_request_data != DW'(wr_acc)) bad_req++;
                    mem[wr_acc] = in_request_data;
                    d = e + longint'($urandom_range(wl_hi, wl_lo));
                    if (d <= last_wdue) d = last_wdue + 1;
                    last_wdue = d;
                    wq_due.push_back(d);
                    wr_acc++;
                end else if (rd_acc < int'(N)) begin
                    if (in_request_type != 1'b0 || in_request_address != AW'(rd_acc)) bad_req++;
                    d = e + longint'($urandom_range(rl_hi, rl_lo));
                    if (d <= last_rdue) d = last_rdue + 1;
                    last_rdue = d;
                    rq_due.push_back(d);
                    rq_addr.push_back(longint'(in_request_address));
                    rd_acc++;
                    if (rd_acc == int'(N)) a = e;
                end else begin
                    bad_req++;
                end
            end
            @(posedge clk); #1;
        end

        write_done = 1'b0; read_done = 1'b0; start = 1'b0; out_busy = 1'b0;
        check({name, ".done_seen"}, got_done, 1);
        check({name, ".req_seq"}, bad_req, 0);
        check({name, ".busy_stable"}, stab_bad, 0);
        check({name, ".accepts"}, wr_acc + rd_acc, 2 * N);
        if (got_done) begin
            // Done follows the last completion; a stalled drain waits TO idle cycles.
            exp_done = (last_strobe > a) ? last_strobe : a;
            if (drop_last) exp_done = exp_done + TO;
            check({name, ".done_edge"}, done_edge, exp_done);
            check({name, ".total_cycles"}, total_cycles, exp_done - s);
            check({name, ".issue_cycles"}, issue_cycles, a - s);
            if (busy_mode == 0) check({name, ".issue_ideal"}, issue_cycles, 2 * N);
            else if (busy_mode == 1) check({name, ".issue_alt"}, issue_cycles, 4 * N);
            check({name, ".error_count"}, error_count, exp_err);
            check({name, ".pass"}, pass, (exp_err == 0 && !drop_last) ? 1 : 0);
            check({name, ".timeout"}, timeout, drop_last ? 1 : 0);
            // Strobes while done must be ignored.
            @(posedge clk); #1;
            write_done = 1'b1; read_done = 1'b1; data_out = DW'($urandom);
            repeat (4) @(posedge clk);
            #1;
            write_done = 1'b0; read_done = 1'b0;
            @(negedge clk);
            check({name, ".done_hold"}, done, 1);
            check({name, ".err_hold"}, error_count, exp_err);
            check({name, ".total_hold"}, total_cycles, exp_done - s);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start.in_valid", in_valid, 0);

        run_sweep("ideal",     0,  5,  5, 5, 5, -1, 1'b0, 1'b0,  -1, 1'b0);
        run_sweep("busy_alt",  1,  5,  5, 5, 5, -1, 1'b0, 1'b0,  -1, 1'b0);
        run_sweep("corrupt7",  0,  5,  5, 5, 5,  7, 1'b0, 1'b0,  -1, 1'b0);
        run_sweep("drop_last", 0,  5,  5, 5, 5, -1, 1'b1, 1'b0,  -1, 1'b0);
        run_sweep("overlap",   0, 20, 20, 3, 3, -1, 1'b0, 1'b1,  -1, 1'b0);
        run_sweep("reset300",  2,  1,  8, 1, 8, -1, 1'b0, 1'b0, 300, 1'b0);
        run_sweep("rerun",     2,  1,  8, 1, 8, -1, 1'b0, 1'b0,  -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
